noc_link_tracer: RTL and testbench
==================================

# noc_link_tracer

Passive NoC link monitor for simulation and debug builds. Taps flit/last/valid/ready on both directions of every tile link, per virtual channel. Captures every completed handshake (valid & ready) as a timestamped trace record and streams the records out through a ready/valid interface. Never drives or back-pressures the observed links.

## Interface
Parameters:
- LINKS, 4, number of tile links observed (1..256)
- CHANNELS, 2, virtual channels per link (1..16)
- FIFO_DEPTH, 16, output record FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- enable  in  1  capture enable; 0 blocks new captures, draining continues
- flit  in  [LINKS-1:0][1:0][CHANNELS-1:0][31:0]  flit per link/dir/channel (dir 0 = out of tile, 1 = into tile)
- last  in  [LINKS-1:0][1:0][CHANNELS-1:0]  last-flit marker
- valid  in  same shape  link valid
- ready  in  same shape  link ready
- trc_valid  out  1  record available
- trc_ready  in  1  consumer accepts record
- trc_data  out  80  record (packed trace_rec_t)
- drop_cnt  out  16  saturating count of lost handshakes

## Operation
- Source index s = (link*2 + dir)*CHANNELS + ch; N = LINKS*2*CHANNELS sources.
- Timestamp: free-running 32-bit counter; 0 on reset; +1 per cycle; wraps at 2^32.
- Record layout, MSB→LSB: ts[31:0], link[7:0], dir[0], ch[3:0], last[0], 2'b00, flit[31:0].
- One pending register per source (valid bit + record). A handshake with enable=1 loads it, using the ts value of the handshake cycle.
- Round-robin arbiter: each cycle, if the FIFO is not full, grant one pending source, starting the search at pointer p. Write its record to the FIFO and clear its pending bit. Set p to grant+1 mod N. p = 0 after reset.
- Handshake on a source whose pending bit is set and not granted this cycle: record dropped. drop_cnt adds the number of drops in that cycle and saturates at 0xFFFF.
- Handshake on a source that is granted in the same cycle: accepted; the pending register reloads.
- Output FIFO is first-word-fall-through. trc_valid = !empty. Pop on trc_valid & trc_ready.
- FIFO full: no grant; pending registers hold.
- Reset (any time): clears pending bits, FIFO, pointer, ts and drop_cnt. Reset mid-operation discards all in-flight records.

## Timing
- Reset values: trc_valid=0, trc_data=0, drop_cnt=0.
- Latency: a handshake at edge t (uncontended, empty FIFO) gives trc_valid=1 after edge t+2.
- Per-source sustained rate: one handshake per cycle with no drops, only if that source is granted every cycle.
- Aggregate throughput: one record per cycle.
- trc_data is stable while trc_valid=1 and trc_ready=0.
- All outputs are registered. There is no combinational path from link inputs to outputs.

## Structure
- Package noc_trace_pkg: trace_rec_t packed struct (80 b), constants TS_W=32, FLIT_W=32, DROP_W=16.
- Sub-module noc_trace_fifo: synchronous FWFT FIFO parameterised by depth and width, same clk/rst.
- Arbiter and pending registers are written inline in the top module.

## Test plan
- Single handshake on link 1, dir 0, ch 1, flit 0xDEADBEEF, last=1, at ts=10 → one record {ts=10, link=1, dir=0, ch=1, last=1, flit=0xDEADBEEF}; trc_valid is 1 after 2 edges.
- All 16 sources (LINKS=4, CHANNELS=2) fire in the same cycle at ts=5, trc_ready=1 → 16 records, all ts=5, emitted in source order 0..15 on consecutive cycles, drop_cnt=0.
- Source 0 handshakes every cycle while sources 1..15 are also pending → drops occur and drop_cnt equals handshakes minus records for source 0; drop_cnt stops at 0xFFFF in a long run.
- trc_ready=0 with 20 handshakes across sources → FIFO holds 16 records, pending registers hold the rest. On release, all records drain in order with trc_data stable while stalled.
- enable=0 with traffic → no records, drop_cnt unchanged; already-queued records still drain.
- rst asserted with the FIFO half full → trc_valid=0 immediately (asynchronous); after release, ts restarts at 0 and drop_cnt=0.

Source files
------------

// File: rtl/noc_trace_pkg.sv
// Shared types and widths for the NoC link tracer: the 80-bit trace record
// and the timestamp, flit and drop-counter widths.
package noc_trace_pkg;

    localparam int TS_W   = 32;
    localparam int FLIT_W = 32;
    localparam int DROP_W = 16;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [7:0]        link;
        logic              dir;
        logic [3:0]        ch;
        logic              last;
        logic [1:0]        rsvd;
        logic [FLIT_W-1:0] flit;
    } trace_rec_t;

endpackage

// File: rtl/noc_trace_fifo.sv
// First-word-fall-through FIFO with a registered head; the head register counts
// toward DEPTH, so the FIFO holds exactly DEPTH entries.
module noc_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push_ok, pop_ok, load;

    always_comb begin
        full     = ({1'b0, mem_cnt_q} + (AW+2)'(out_valid_q)) == (AW+2)'(DEPTH);
        push_ok  = push && !full;
        pop_ok   = pop && out_valid_q;
        load     = (mem_cnt_q != '0) && (!out_valid_q || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + (AW+1)'(push_ok) - (AW+1)'(load);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end else if (pop_ok) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/noc_link_tracer.sv
// Passive NoC link monitor: captures every link handshake into a per-source
// pending register and streams timestamped records out through a FIFO.
module noc_link_tracer
    import noc_trace_pkg::*;
#(
    parameter int LINKS      = 4,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic [LINKS-1:0][1:0][CHANNELS-1:0][31:0] flit,
    input  logic [LINKS-1:0][1:0][CHANNELS-1:0]       last,
    input  logic [LINKS-1:0][1:0][CHANNELS-1:0]       valid,
    input  logic [LINKS-1:0][1:0][CHANNELS-1:0]       ready,
    output logic                                      trc_valid,
    input  logic                                      trc_ready,
    output logic [79:0]                               trc_data,
    output logic [15:0]                               drop_cnt
);

    localparam int N   = LINKS * 2 * CHANNELS;
    localparam int SW  = (N > 1) ? $clog2(N) : 1;
    localparam int DCW = $clog2(N + 1);

    // The packed port layout already flattens to source order (link*2+dir)*CHANNELS+ch.
    logic [N-1:0][FLIT_W-1:0] flit_s;
    logic [N-1:0]             last_s, valid_s, ready_s, hs;

    assign flit_s  = flit;
    assign last_s  = last;
    assign valid_s = valid;
    assign ready_s = ready;
    assign hs      = valid_s & ready_s & {N{enable}};

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [SW-1:0]     ptr_q, ptr_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [N-1:0]      pend_vld_q, pend_vld_d;
    trace_rec_t        pend_rec_q [N];
    trace_rec_t        pend_rec_d [N];

    logic              fifo_full;
    logic              grant_vld;
    logic [SW-1:0]     grant_idx;
    logic [SW-1:0]     scan_idx;
    logic [DCW-1:0]    drops;
    logic [DROP_W:0]   drop_sum;
    trace_rec_t        grant_rec;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (!fifo_full) begin
            for (int k = 0; k < N; k++) begin
                scan_idx = SW'((int'(ptr_q) + k) % N);
                if (!grant_vld && pend_vld_q[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        grant_rec = pend_rec_q[grant_idx];
    end

    // A handshake is lost only when its source still holds an ungranted record.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_rec_d = pend_rec_q;
        drops      = '0;
        for (int s = 0; s < N; s++) begin
            if (hs[s]) begin
                if (pend_vld_q[s] && !(grant_vld && grant_idx == SW'(s))) begin
                    drops = drops + DCW'(1);
                end else begin
                    pend_vld_d[s]      = 1'b1;
                    pend_rec_d[s].ts   = ts_q;
                    pend_rec_d[s].link = 8'(s / (2 * CHANNELS));
                    pend_rec_d[s].dir  = 1'((s / CHANNELS) % 2);
                    pend_rec_d[s].ch   = 4'(s % CHANNELS);
                    pend_rec_d[s].last = last_s[s];
                    pend_rec_d[s].rsvd = 2'b00;
                    pend_rec_d[s].flit = flit_s[s];
                end
            end else if (grant_vld && grant_idx == SW'(s)) begin
                pend_vld_d[s] = 1'b0;
            end
        end
    end

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        ptr_d      = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
        end
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'(drops);
        drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            ptr_q      <= '0;
            drop_cnt_q <= '0;
            pend_vld_q <= '0;
            for (int s = 0; s < N; s++) begin
                pend_rec_q[s] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            ptr_q      <= ptr_d;
            drop_cnt_q <= drop_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_rec_q <= pend_rec_d;
        end
    end

    noc_trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_vld),
        .push_data (grant_rec),
        .full      (fifo_full),
        .pop       (trc_ready),
        .out_valid (trc_valid),
        .out_data  (trc_data)
    );

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_noc_link_tracer.sv
// Directed self-checking bench for noc_link_tracer (LINKS=4, CHANNELS=2, FIFO_DEPTH=16).
module tb_noc_link_tracer;

    localparam int LINKS      = 4;
    localparam int CHANNELS   = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int N          = LINKS * 2 * CHANNELS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic trc_ready = 1'b0;

    logic [LINKS-1:0][1:0][CHANNELS-1:0][31:0] flit;
    logic [LINKS-1:0][1:0][CHANNELS-1:0]       last, valid, ready;
    logic [N-1:0][31:0] flit_s = '0;
    logic [N-1:0]       last_s = '0, valid_s = '0, ready_s = '0;

    logic        trc_valid;
    logic [79:0] trc_data;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;
    int pop_total = 0;
    int src0_pops = 0;
    logic [31:0] tb_ts;

    assign flit  = flit_s;
    assign last  = last_s;
    assign valid = valid_s;
    assign ready = ready_s;

    noc_link_tracer #(
        .LINKS      (LINKS),
        .CHANNELS   (CHANNELS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .flit      (flit),
        .last      (last),
        .valid     (valid),
        .ready     (ready),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_data  (trc_data),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference timestamp, counted independently of the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_ts <= '0;
        else      tb_ts <= tb_ts + 32'd1;
    end

    always @(posedge clk) begin
        if (rst && trc_valid && trc_ready) begin
            pop_total <= pop_total + 1;
            if (trc_data[47:35] == 13'd0) src0_pops <= src0_pops + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives a handshake on every source in mask for one cycle, then idles the links.
    task automatic applyStimulus(input logic [N-1:0] mask, input logic [31:0] base);
        for (int s = 0; s < N; s++) begin
            valid_s[s] = mask[s];
            ready_s[s] = mask[s];
            flit_s[s]  = base + 32'(s);
            last_s[s]  = 1'(s % 2);
        end
        @(negedge clk);
        valid_s = '0;
        ready_s = '0;
    endtask

    task automatic resetDut();
        valid_s   = '0;
        ready_s   = '0;
        trc_ready = 1'b0;
        enable    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitTs(input logic [31:0] target);
        while (tb_ts != target) @(negedge clk);
    endtask

    function automatic logic [79:0] expRec(input int s, input logic [31:0] ts,
                                           input logic [31:0] fl, input logic lst);
        logic [7:0] lk;
        logic       d;
        logic [3:0] c;
        lk = 8'(s / (2 * CHANNELS));
        d  = 1'((s / CHANNELS) % 2);
        c  = 4'(s % CHANNELS);
        return {ts, lk, d, c, lst, 2'b00, fl};
    endfunction

    initial begin
        logic [79:0] exp_q [$];
        logic [31:0] ta, tb2;
        int idx, cnt, p0, s0;

        // Reset values while reset is held.
        @(negedge clk);
        checkOutput("rst_valid", 80'(trc_valid), 80'd0);
        checkOutput("rst_data", trc_data, 80'd0);
        checkOutput("rst_drop", 80'(drop_cnt), 80'd0);

        // Single handshake on link 1, dir 0, ch 1 at ts=10 (base chosen so source 5 gets DEADBEEF).
        resetDut();
        waitTs(32'd10);
        applyStimulus(16'h0020, 32'hDEADBEEA);
        checkOutput("lat_edge0", 80'(trc_valid), 80'd0);
        @(negedge clk);
        checkOutput("lat_edge1", 80'(trc_valid), 80'd0);
        @(negedge clk);
        checkOutput("lat_edge2", 80'(trc_valid), 80'd1);
        checkOutput("single_rec", trc_data, expRec(5, 32'd10, 32'hDEADBEEF, 1'b1));
        trc_ready = 1'b1;
        @(negedge clk);
        checkOutput("single_pop", 80'(trc_valid), 80'd0);

        // All sources at ts=5, drained in source order on consecutive cycles.
        resetDut();
        trc_ready = 1'b1;
        waitTs(32'd5);
        applyStimulus('1, 32'hA0000000);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            checkOutput("burst_valid", 80'(trc_valid), 80'd1);
            checkOutput("burst_rec", trc_data, expRec(i, 32'd5, 32'hA0000000 + 32'(i), 1'(i % 2)));
        end
        @(negedge clk);
        checkOutput("burst_end", 80'(trc_valid), 80'd0);
        checkOutput("burst_drop", 80'(drop_cnt), 80'd0);

        // Source 0 hammers while 1..15 are pending: 15 drops, 5 records from source 0.
        resetDut();
        trc_ready = 1'b1;
        p0 = pop_total;
        s0 = src0_pops;
        applyStimulus('1, 32'h10000000);
        for (int i = 0; i < 19; i++) applyStimulus(16'h0001, 32'h20000000);
        repeat (30) @(negedge clk);
        checkOutput("hammer_drop", 80'(drop_cnt), 80'd15);
        checkOutput("hammer_pops", 80'(pop_total - p0), 80'd20);
        checkOutput("hammer_src0", 80'(src0_pops - s0), 80'd5);

        // Saturation: FIFO stalled, every source firing every cycle.
        resetDut();
        for (int i = 0; i < 20; i++) applyStimulus('1, 32'h30000000);
        checkOutput("sat_partial", 80'(drop_cnt), 80'd288);
        for (int i = 0; i < 4100; i++) applyStimulus('1, 32'h30000000);
        checkOutput("sat_max", 80'(drop_cnt), 80'hFFFF);
        checkOutput("sat_valid", 80'(trc_valid), 80'd1);

        // 20 handshakes with the consumer stalled: 16 queued, 4 held pending.
        resetDut();
        ta = tb_ts;
        applyStimulus('1, 32'hB0000000);
        repeat (4) applyStimulus('0, 32'h0);
        tb2 = tb_ts;
        applyStimulus(16'h000F, 32'hC0000000);
        repeat (15) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(expRec(i, ta, 32'hB0000000 + 32'(i), 1'(i % 2)));
        for (int i = 0; i < 4; i++) exp_q.push_back(expRec(i, tb2, 32'hC0000000 + 32'(i), 1'(i % 2)));
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_valid", 80'(trc_valid), 80'd1);
            checkOutput("stall_hold", trc_data, exp_q[0]);
            @(negedge clk);
        end
        trc_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 60 && idx < 20; c++) begin
            if (trc_valid) begin
                checkOutput("stall_drain", trc_data, exp_q[idx]);
                idx++;
            end
            @(negedge clk);
        end
        checkOutput("stall_count", 80'(idx), 80'd20);
        checkOutput("stall_drop", 80'(drop_cnt), 80'd0);

        // enable=0: traffic ignored, already-queued record still drains.
        resetDut();
        ta = tb_ts;
        applyStimulus(16'h0004, 32'h50000000);
        enable = 1'b0;
        repeat (10) applyStimulus('1, 32'h60000000);
        checkOutput("en_drop_hold", 80'(drop_cnt), 80'd0);
        trc_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (trc_valid) begin
                checkOutput("en_rec", trc_data, expRec(2, ta, 32'h50000002, 1'b0));
                cnt++;
            end
            applyStimulus('1, 32'h60000000);
        end
        checkOutput("en_count", 80'(cnt), 80'd1);
        checkOutput("en_drop_end", 80'(drop_cnt), 80'd0);
        enable = 1'b1;

        // Asynchronous reset with the FIFO half full and drops recorded.
        resetDut();
        applyStimulus(16'h00FF, 32'h70000000);
        applyStimulus(16'h00FF, 32'h70000000);
        repeat (10) @(negedge clk);
        checkOutput("pre_rst_drop", 80'(drop_cnt), 80'd7);
        checkOutput("pre_rst_valid", 80'(trc_valid), 80'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_valid", 80'(trc_valid), 80'd0);
        checkOutput("async_data", trc_data, 80'd0);
        checkOutput("async_drop", 80'(drop_cnt), 80'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'h0008, 32'h80000000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_rst_valid", 80'(trc_valid), 80'd1);
        checkOutput("post_rst_rec", trc_data, expRec(3, 32'd0, 32'h80000003, 1'b1));
        checkOutput("post_rst_drop", 80'(drop_cnt), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
